// File: rtl/page_walker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : page_walker_pkg
// Brief    : Shared types and constants for the two-level page-table walker:
//            FSM state encoding, descriptor bit positions, fault codes and
//            the memory-controller access-size constant.
// Revision : 1.0 - initial release
// ============================================================================
package page_walker_pkg;

    // Walker FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_L1_REQ  = 3'd1,
        ST_L1_WAIT = 3'd2,
        ST_L2_REQ  = 3'd3,
        ST_L2_WAIT = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Descriptor bit positions
    localparam int DESC_VALID   = 0;
    localparam int DESC_WRITE   = 1;
    localparam int DESC_USER    = 2;
    localparam int DESC_PPN_LSB = 8;
    localparam int DESC_PPN_MSB = 13;

    // Fault codes reported on out_resp_fault
    localparam logic [1:0] FAULT_NONE = 2'd0;
    localparam logic [1:0] FAULT_L1   = 2'd1;
    localparam logic [1:0] FAULT_L2   = 2'd2;
    localparam logic [1:0] FAULT_PERM = 2'd3;

    // Access size driven with every descriptor fetch
    localparam logic [1:0] WORD = 2'b10;

    // Word-aligned byte address of entry `idx` in the 256 B table at `base`
    function automatic logic [13:0] table_entry_addr(input logic [5:0] base,
                                                     input logic [5:0] idx);
        return {base, idx, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/page_walker_l1_cache.sv
`default_nettype none
// ============================================================================
// Module   : page_walker_l1_cache
// Brief    : Single-entry cache of the last valid L1 descriptor, tagged by
//            the table base and L1 index. Only used when the top is built
//            with PAGE_WALKER_L1_CACHE_EN. A flush beats a same-cycle fill.
// Revision : 1.0 - initial release
// ============================================================================
module page_walker_l1_cache (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       fill,
    input  logic [5:0] fill_base,
    input  logic [5:0] fill_idx,
    input  logic [5:0] fill_ppn,
    input  logic [5:0] look_base,
    input  logic [5:0] look_idx,
    output logic       hit,
    output logic [5:0] hit_ppn
);

    logic       entry_valid;
    logic [5:0] tag_base;
    logic [5:0] tag_idx;
    logic [5:0] entry_ppn;

    // Entry update: flush invalidates, otherwise a valid L1 capture refills
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entry_valid <= 1'b0;
            tag_base    <= '0;
            tag_idx     <= '0;
            entry_ppn   <= '0;
        end else if (flush) begin
            entry_valid <= 1'b0;
        end else if (fill) begin
            entry_valid <= 1'b1;
            tag_base    <= fill_base;
            tag_idx     <= fill_idx;
            entry_ppn   <= fill_ppn;
        end
    end

    assign hit     = entry_valid && (tag_base == look_base) && (tag_idx == look_idx);
    assign hit_ppn = entry_ppn;

endmodule
`default_nettype wire

// File: rtl/page_walker.sv
`default_nettype none
// ============================================================================
// Module   : page_walker
// Brief    : MMU page-table walker. Walks a two-level table through the
//            memory controller read port and returns a 14-bit physical
//            address or a fault code. One walk in flight at a time.
//            Optional single-entry L1 descriptor cache: PAGE_WALKER_L1_CACHE_EN
// Revision : 1.0 - initial release
// ============================================================================
module page_walker
    import page_walker_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_walk_valid,
    output logic        out_walk_ready,
    input  logic [19:0] in_walk_vaddr,
    input  logic        in_walk_write,
    input  logic [13:0] in_ttbr,
    input  logic        in_flush,
    output logic        out_dram_ren,
    output logic [13:0] out_dram_addr,
    output logic [1:0]  out_dram_size,
    input  logic [31:0] in_mcu_data,
    output logic        out_resp_valid,
    output logic [13:0] out_resp_paddr,
    output logic [1:0]  out_resp_fault,
    output logic [1:0]  out_resp_flags
);

    localparam int               CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [19:0]      vaddr_q;
    logic             write_q;
    logic [5:0]       ttbr_q;

    logic             data_now;
    logic [5:0]       data_ppn;
    logic             cache_hit;
    logic [5:0]       cache_ppn;
    logic             cache_fill;

    // Descriptor is on in_mcu_data in the last wait cycle
    assign data_now   = (wait_cnt == CNT_ONE);
    assign data_ppn   = in_mcu_data[DESC_PPN_MSB:DESC_PPN_LSB];
    assign cache_fill = (state == ST_L1_WAIT) && data_now && in_mcu_data[DESC_VALID];

`ifdef PAGE_WALKER_L1_CACHE_EN
    // Lookup uses the live request so a hit can skip the L1 fetch at accept
    page_walker_l1_cache u_l1_cache (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (in_flush),
        .fill      (cache_fill),
        .fill_base (ttbr_q),
        .fill_idx  (vaddr_q[19:14]),
        .fill_ppn  (data_ppn),
        .look_base (in_ttbr[13:8]),
        .look_idx  (in_walk_vaddr[19:14]),
        .hit       (cache_hit),
        .hit_ppn   (cache_ppn)
    );

    logic unused_bits;
    assign unused_bits = &{1'b0, in_ttbr[7:0], in_mcu_data[31:14], in_mcu_data[7:3]};
`else
    // No cache: every walk fetches L1 and flush is a no-op
    assign cache_hit = 1'b0;
    assign cache_ppn = '0;

    logic unused_bits;
    assign unused_bits = &{1'b0, in_ttbr[7:0], in_mcu_data[31:14], in_mcu_data[7:3],
                           in_flush, cache_fill, ttbr_q, vaddr_q[19:14]};
`endif

    // Walk FSM with all outputs registered; pulses default low every cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            vaddr_q        <= '0;
            write_q        <= 1'b0;
            ttbr_q         <= '0;
            out_walk_ready <= 1'b1;
            out_dram_ren   <= 1'b0;
            out_dram_addr  <= '0;
            out_dram_size  <= '0;
            out_resp_valid <= 1'b0;
            out_resp_paddr <= '0;
            out_resp_fault <= FAULT_NONE;
            out_resp_flags <= '0;
        end else begin
            out_dram_ren   <= 1'b0;
            out_dram_addr  <= '0;
            out_dram_size  <= '0;
            out_resp_valid <= 1'b0;
            out_resp_paddr <= '0;
            out_resp_fault <= FAULT_NONE;
            out_resp_flags <= '0;

            case (state)
                ST_IDLE: begin
                    if (in_walk_valid) begin
                        vaddr_q        <= in_walk_vaddr;
                        write_q        <= in_walk_write;
                        ttbr_q         <= in_ttbr[13:8];
                        out_walk_ready <= 1'b0;
                        out_dram_ren   <= 1'b1;
                        out_dram_size  <= WORD;
                        if (cache_hit) begin
                            out_dram_addr <= table_entry_addr(cache_ppn, in_walk_vaddr[13:8]);
                            state         <= ST_L2_REQ;
                        end else begin
                            out_dram_addr <= table_entry_addr(in_ttbr[13:8], in_walk_vaddr[19:14]);
                            state         <= ST_L1_REQ;
                        end
                    end
                end

                ST_L1_REQ: begin
                    wait_cnt <= CNT_LOAD;
                    state    <= ST_L1_WAIT;
                end

                ST_L1_WAIT: begin
                    if (data_now) begin
                        if (in_mcu_data[DESC_VALID]) begin
                            out_dram_ren  <= 1'b1;
                            out_dram_size <= WORD;
                            out_dram_addr <= table_entry_addr(data_ppn, vaddr_q[13:8]);
                            state         <= ST_L2_REQ;
                        end else begin
                            out_resp_valid <= 1'b1;
                            out_resp_fault <= FAULT_L1;
                            state          <= ST_DONE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CNT_ONE;
                    end
                end

                ST_L2_REQ: begin
                    wait_cnt <= CNT_LOAD;
                    state    <= ST_L2_WAIT;
                end

                ST_L2_WAIT: begin
                    if (data_now) begin
                        out_resp_valid <= 1'b1;
                        out_resp_flags <= {in_mcu_data[DESC_USER], in_mcu_data[DESC_WRITE]};
                        if (!in_mcu_data[DESC_VALID]) begin
                            out_resp_fault <= FAULT_L2;
                        end else if (write_q && !in_mcu_data[DESC_WRITE]) begin
                            out_resp_fault <= FAULT_PERM;
                        end else begin
                            out_resp_fault <= FAULT_NONE;
                            out_resp_paddr <= {data_ppn, vaddr_q[7:0]};
                        end
                        state <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_ONE;
                    end
                end

                ST_DONE: begin
                    out_walk_ready <= 1'b1;
                    state          <= ST_IDLE;
                end

                default: begin
                    out_walk_ready <= 1'b1;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_page_walker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_page_walker
// Brief    : Self-checking bench for page_walker. A transaction-level model
//            predicts every output on every cycle from the walk rules; a
//            memory-controller model answers reads MEM_LAT cycles later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_page_walker;

    localparam int MEM_LAT = 2;
`ifdef PAGE_WALKER_L1_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_walk_valid = 1'b0;
    logic        out_walk_ready;
    logic [19:0] in_walk_vaddr = '0;
    logic        in_walk_write = 1'b0;
    logic [13:0] in_ttbr = '0;
    logic        in_flush = 1'b0;
    logic        out_dram_ren;
    logic [13:0] out_dram_addr;
    logic [1:0]  out_dram_size;
    logic [31:0] in_mcu_data = '0;
    logic        out_resp_valid;
    logic [13:0] out_resp_paddr;
    logic [1:0]  out_resp_fault;
    logic [1:0]  out_resp_flags;

    always #5 clock = ~clock;

    page_walker #(.MEM_LAT(MEM_LAT)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_walk_valid  (in_walk_valid),
        .out_walk_ready (out_walk_ready),
        .in_walk_vaddr  (in_walk_vaddr),
        .in_walk_write  (in_walk_write),
        .in_ttbr        (in_ttbr),
        .in_flush       (in_flush),
        .out_dram_ren   (out_dram_ren),
        .out_dram_addr  (out_dram_addr),
        .out_dram_size  (out_dram_size),
        .in_mcu_data    (in_mcu_data),
        .out_resp_valid (out_resp_valid),
        .out_resp_paddr (out_resp_paddr),
        .out_resp_fault (out_resp_fault),
        .out_resp_flags (out_resp_flags)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit in_reset = 1'b1;

    logic [31:0] mem [0:4095];
    bit          ren_h  [16];
    logic [13:0] addr_h [16];

    // Model of the walk in flight (all in plain integers)
    bit busy = 1'b0;
    int s = 0;
    int done_k = 0;
    int acc_cnt = 0;
    bit m_hit, m_l1ok;
    int m_a1, m_a2, m_paddr, m_fault, m_flags, m_base, m_idx, m_l1ppn;
    // Model of the single-entry L1 cache
    bit c_valid = 1'b0;
    int c_base, c_idx, c_ppn;

    // Monitor log for directed literal checks
    int rd_cnt = 0;
    int rd_addr [8];
    int rd_cyc  [8];
    int resp_n = 0;
    int resp_cyc = 0;
    int r_paddr, r_fault, r_flags;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_ready(input int c);
        return !busy || (c > s + done_k);
    endfunction

    task automatic start_walk();
        int va, tb, l2i, off, l2ppn;
        logic [31:0] l1d, l2d;
        va     = int'(in_walk_vaddr);
        tb     = int'(in_ttbr) / 256;
        m_idx  = va / 16384;
        l2i    = (va / 256) % 64;
        off    = va % 256;
        m_base = tb;
        m_a1   = tb * 256 + m_idx * 4;
        m_hit  = CACHE && c_valid && (c_base == tb) && (c_idx == m_idx);
        if (m_hit) begin
            m_l1ok   = 1'b1;
            m_l1ppn  = c_ppn;
        end else begin
            l1d      = mem[m_a1 / 4];
            m_l1ok   = l1d[0];
            m_l1ppn  = int'(l1d % 16384) / 256;
        end
        m_a2    = m_l1ppn * 256 + l2i * 4;
        l2d     = mem[m_a2 / 4];
        l2ppn   = int'(l2d % 16384) / 256;
        m_paddr = 0;
        if (!m_l1ok) begin
            m_fault = 1; m_flags = 0; done_k = 2 + MEM_LAT;
        end else begin
            m_flags = int'(l2d[2]) * 2 + int'(l2d[1]);
            if (!l2d[0])                          m_fault = 2;
            else if (in_walk_write && !l2d[1])    m_fault = 3;
            else begin m_fault = 0; m_paddr = l2ppn * 256 + off; end
            done_k = m_hit ? (2 + MEM_LAT) : (3 + 2 * MEM_LAT);
        end
        s    = cyc;
        busy = 1'b1;
        acc_cnt++;
    endtask

    // Model state at each rising edge: accept, then cache fill/flush
    task automatic model_edge();
        bit fill_now;
        int fb, fi, fp;
        fill_now = busy && !m_hit && m_l1ok && (cyc == s + 1 + MEM_LAT);
        fb = m_base; fi = m_idx; fp = m_l1ppn;
        if (model_ready(cyc) && in_walk_valid === 1'b1) start_walk();
        if (CACHE) begin
            if (in_flush === 1'b1) c_valid = 1'b0;
            else if (fill_now) begin
                c_valid = 1'b1; c_base = fb; c_idx = fi; c_ppn = fp;
            end
        end
    endtask

    function automatic logic [36:0] exp_vec(input int c);
        logic       e_ready, e_ren, e_rv;
        logic [13:0] e_addr, e_paddr;
        logic [1:0] e_fault, e_flags;
        int k;
        k = c - s;
        e_ready = model_ready(c);
        e_ren = 1'b0; e_addr = '0; e_rv = 1'b0; e_paddr = '0; e_fault = '0; e_flags = '0;
        if (busy) begin
            if (k == 1) begin e_ren = 1'b1; e_addr = 14'(m_hit ? m_a2 : m_a1); end
            if (!m_hit && m_l1ok && k == 2 + MEM_LAT) begin e_ren = 1'b1; e_addr = 14'(m_a2); end
            if (k == done_k) begin
                e_rv = 1'b1; e_paddr = 14'(m_paddr); e_fault = 2'(m_fault); e_flags = 2'(m_flags);
            end
        end
        return {e_ready, e_ren, e_addr, (e_ren ? 2'b10 : 2'b00), e_rv, e_paddr, e_fault, e_flags};
    endfunction

    function automatic logic [36:0] act_vec();
        return {out_walk_ready, out_dram_ren, out_dram_addr, out_dram_size,
                out_resp_valid, out_resp_paddr, out_resp_fault, out_resp_flags};
    endfunction

    // Rising edge: model step, cycle count, then memory data for the new cycle
    initial begin
        forever begin
            @(posedge clock);
            if (!in_reset) model_edge();
            cyc++;
            #1;
            if (cyc - MEM_LAT >= 0 && ren_h[(cyc - MEM_LAT) % 16])
                in_mcu_data = mem[addr_h[(cyc - MEM_LAT) % 16][13:2]];
            else
                in_mcu_data = $urandom;
        end
    end

    // Falling edge: record reads, log responses, compare against the model
    initial begin
        forever begin
            @(negedge clock);
            ren_h[cyc % 16]  = out_dram_ren;
            addr_h[cyc % 16] = out_dram_addr;
            if (!in_reset) begin
                if (out_dram_ren) begin
                    if (rd_cnt < 8) begin rd_addr[rd_cnt] = int'(out_dram_addr); rd_cyc[rd_cnt] = cyc; end
                    rd_cnt++;
                end
                if (out_resp_valid) begin
                    resp_n++; resp_cyc = cyc;
                    r_paddr = int'(out_resp_paddr); r_fault = int'(out_resp_fault); r_flags = int'(out_resp_flags);
                end
                chk("outputs_vs_model", 64'(act_vec()), 64'(exp_vec(cyc)));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!model_ready(cyc) && n < 60) begin @(negedge clock); n++; end
        if (!model_ready(cyc)) chk("walk_done_timeout", 64'(0), 64'(1));
    endtask

    // Present a request, hold it until accepted, then scramble the inputs
    task automatic walk(input int va, input bit wr, input int tt, input bit rnd_flush);
        int a0, n;
        a0 = acc_cnt; n = 0;
        in_walk_vaddr = 20'(va); in_walk_write = wr; in_ttbr = 14'(tt); in_walk_valid = 1'b1;
        while (acc_cnt == a0 && n < 60) begin
            @(negedge clock); n++;
            in_flush = rnd_flush && ($urandom_range(0, 7) == 0);
        end
        if (acc_cnt == a0) chk("accept_timeout", 64'(0), 64'(1));
        in_walk_valid = 1'b0;
        in_walk_vaddr = 20'($urandom); in_walk_write = 1'($urandom); in_ttbr = 14'($urandom);
        n = 0;
        while (!model_ready(cyc) && n < 60) begin
            @(negedge clock); n++;
            in_flush = rnd_flush && ($urandom_range(0, 7) == 0);
        end
        if (!model_ready(cyc)) chk("walk_done_timeout", 64'(0), 64'(1));
        in_flush = 1'b0;
    endtask

    task automatic flush_pulse();
        @(negedge clock); in_flush = 1'b1;
        @(negedge clock); in_flush = 1'b0;
    endtask

    task automatic clear_log();
        rd_cnt = 0; resp_n = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int tmp, a0, n;
        for (int i = 0; i < 4096; i++) begin
            tmp = int'($urandom);
            mem[i] = 32'(tmp);
            mem[i][0] = ($urandom_range(0, 9) >= 2);
        end
        mem[14'h144 / 4] = 32'h0000_0203;
        mem[14'h268 / 4] = 32'h0000_3F07;

        // Reset state
        repeat (3) @(posedge clock);
        #2;
        chk("reset_state", 64'(act_vec()), 64'({1'b1, 36'b0}));
        @(negedge clock); reset_n = 1'b1; in_reset = 1'b0;
        repeat (2) @(negedge clock);

        // Successful walk
        clear_log();
        walk(32'h45A3C, 1'b0, 32'h0100, 1'b0);
        chk("ok_read_count", 64'(rd_cnt), 64'(2));
        chk("ok_l1_addr", 64'(rd_addr[0]), 64'h144);
        chk("ok_l2_addr", 64'(rd_addr[1]), 64'h268);
        chk("ok_resp_cycle", 64'(resp_cyc - s), 64'(7));
        chk("ok_paddr", 64'(r_paddr), 64'h3F3C);
        chk("ok_fault", 64'(r_fault), 64'(0));
        chk("ok_flags", 64'(r_flags), 64'(3));
        chk("model_pin_paddr", 64'(m_paddr), 64'h3F3C);

`ifdef PAGE_WALKER_L1_CACHE_EN
        // Cache hit skips L1, then a flush forces the L1 fetch again
        clear_log();
        walk(32'h45A3C, 1'b0, 32'h0100, 1'b0);
        chk("hit_read_count", 64'(rd_cnt), 64'(1));
        chk("hit_l2_addr", 64'(rd_addr[0]), 64'h268);
        chk("hit_resp_cycle", 64'(resp_cyc - s), 64'(4));
        chk("hit_paddr", 64'(r_paddr), 64'h3F3C);
        flush_pulse();
        clear_log();
        walk(32'h45A3C, 1'b0, 32'h0100, 1'b0);
        chk("flush_l1_reissued", 64'(rd_addr[0]), 64'h144);
        chk("flush_read_count", 64'(rd_cnt), 64'(2));
`endif

        // L1 fault
        mem[14'h144 / 4] = 32'h0000_0200;
        flush_pulse();
        clear_log();
        walk(32'h45A3C, 1'b0, 32'h0100, 1'b0);
        chk("l1f_read_count", 64'(rd_cnt), 64'(1));
        chk("l1f_resp_cycle", 64'(resp_cyc - s), 64'(4));
        chk("l1f_fault", 64'(r_fault), 64'(1));
        chk("l1f_paddr", 64'(r_paddr), 64'(0));
        mem[14'h144 / 4] = 32'h0000_0203;

        // Permission fault on store, same walk succeeds as a load
        mem[14'h268 / 4] = 32'h0000_3F05;
        flush_pulse();
        clear_log();
        walk(32'h45A3C, 1'b1, 32'h0100, 1'b0);
        chk("perm_fault", 64'(r_fault), 64'(3));
        chk("perm_flags", 64'(r_flags), 64'(2));
        chk("perm_paddr", 64'(r_paddr), 64'(0));
        clear_log();
        walk(32'h45A3C, 1'b0, 32'h0100, 1'b0);
        chk("load_paddr", 64'(r_paddr), 64'h3F3C);
        chk("load_fault", 64'(r_fault), 64'(0));

        // Request held during a walk is accepted after resp plus one IDLE cycle
        flush_pulse();
        clear_log();
        a0 = acc_cnt; n = 0;
        in_walk_vaddr = 20'h45A3C; in_walk_write = 1'b0; in_ttbr = 14'h0100; in_walk_valid = 1'b1;
        while (acc_cnt == a0 && n < 60) begin @(negedge clock); n++; end
        in_walk_vaddr = 20'hC1234;
        while (acc_cnt < a0 + 2 && n < 120) begin @(negedge clock); n++; end
        if (acc_cnt < a0 + 2) chk("held_accept_timeout", 64'(0), 64'(1));
        in_walk_valid = 1'b0;
        wait_idle();
        chk("held_read_gap", 64'(rd_cyc[2] - rd_cyc[0]), 64'(8));
        chk("held_new_l1_addr", 64'(rd_addr[2]), 64'h1C0);
        chk("held_first_l2_addr", 64'(rd_addr[1]), 64'h268);

        // Reset asserted in L2_WAIT aborts the walk with no response
        clear_log();
        a0 = acc_cnt; n = 0;
        in_walk_vaddr = 20'h45A3C; in_ttbr = 14'h0100; in_walk_valid = 1'b1;
        while (acc_cnt == a0 && n < 60) begin @(negedge clock); n++; end
        in_walk_valid = 1'b0;
        while (cyc < s + 3 + MEM_LAT && n < 120) begin @(negedge clock); n++; end
        #2;
        reset_n = 1'b0; in_reset = 1'b1; busy = 1'b0; c_valid = 1'b0;
        #1;
        chk("midwalk_reset_outputs", 64'(act_vec()), 64'({1'b1, 36'b0}));
        repeat (2) @(negedge clock);
        #2; reset_n = 1'b1; in_reset = 1'b0;
        resp_n = 0;
        @(negedge clock);
        chk("ready_after_release", 64'(out_walk_ready), 64'(1));
        repeat (12) @(negedge clock);
        chk("no_resp_after_abort", 64'(resp_n), 64'(0));

        // Randomized walks with garbage inputs, random flushes and gaps
        for (int w = 0; w < 300; w++) begin
            int l1i, va, tt, gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clock);
                in_walk_vaddr = 20'($urandom); in_ttbr = 14'($urandom);
                in_flush = ($urandom_range(0, 5) == 0);
            end
            l1i = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(16, 18);
            va  = l1i * 16384 + $urandom_range(0, 16383);
            tt  = (($urandom_range(0, 1) == 1) ? 1 : $urandom_range(0, 63)) * 256 + $urandom_range(0, 255);
            walk(va, 1'($urandom), tt, 1'b1);
        end

        repeat (4) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
